button_debounce_pulse: RTL and testbench

- Input conditioning stage directly upstream of the stopwatch control logic. It takes raw mechanical push-button levels from ui_in, synchronises and debounces each one, and delivers clean levels plus single-cycle press and release events.
- The stopwatch consumes btn_press[0..2] as clear, start and stop commands, replacing its direct sampling of the raw pins.
- Each button is handled by an independent, identical channel.

---
 rtl/button_debounce_pulse.sv | 188 ++++++++++++++++++
 tb/tb_button_debounce_pulse.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
// ---------------------------------------------------------------------------------------------
// button_debounce_pulse
//
// Input conditioning for the stopwatch push-buttons. Each of N_BTN identical and independent
// channels synchronises a raw mechanical button level through two flops. It then debounces the
// level with a stable-cycle counter and produces a clean registered level plus single-cycle
// press and release events.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset, clears all state ("all buttons released")
//   btn_raw      [N_BTN] raw asynchronous button levels, active high
//   btn_level    [N_BTN] debounced, registered button level
//   btn_press    [N_BTN] one-cycle pulse on each accepted 0->1 transition of btn_level
//   btn_release  [N_BTN] one-cycle pulse on each accepted 1->0 transition of btn_level
//
// Parameters:
//   N_BTN            number of button channels
//   DEBOUNCE_CYCLES  consecutive stable cycles before a level change is accepted (>= 1)
//   REPEAT_DELAY     cycles from a press pulse to the first auto-repeat press (>= 2)
//   REPEAT_PERIOD    cycles between subsequent auto-repeat presses (>= 2)
//
// Optional feature:
//   Define DEBOUNCE_AUTO_REPEAT_EN to add per-channel auto-repeat. While a debounced button
//   stays pressed, extra btn_press pulses fire REPEAT_DELAY cycles after the original press
//   and then every REPEAT_PERIOD cycles. Without the macro the repeat logic is absent.
// ---------------------------------------------------------------------------------------------
module button_debounce_pulse #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  // A repeat interval of 1 would merge consecutive pulses into a multi-cycle level.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
  end

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [CntW-1:0]  cnt_q [N_BTN];
  logic [CntW-1:0]  cnt_d [N_BTN];

  // A channel accepts its synchronised level in the cycle it has disagreed with the stable
  // level for DEBOUNCE_CYCLES consecutive samples.
  logic [N_BTN-1:0] accept;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      accept[i] = (sync2_q[i] != level_q[i]) && (cnt_q[i] == CntMax);
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  // -------------------------------------------------------------------------------------------
  // Auto-repeat
  // -------------------------------------------------------------------------------------------
  localparam int unsigned RptMaxCycles =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMaxCycles + 1);
  localparam logic [RptW-1:0] RptDelayMax  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodMax = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0]  rpt_cnt_q [N_BTN];
  logic [RptW-1:0]  rpt_cnt_d [N_BTN];
  // rpt_run: 0 while waiting out the initial delay, 1 once periodic repeats have begun.
  logic [N_BTN-1:0] rpt_run_q, rpt_run_d;
  logic [N_BTN-1:0] rpt_fire;

  always_comb begin
    rpt_fire  = '0;
    rpt_run_d = rpt_run_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (accept[i] || !level_q[i]) begin
        // Restart on every genuine press/release and hold idle while released. A release
        // accepted this cycle therefore suppresses any repeat that would have coincided.
        rpt_cnt_d[i] = '0;
        rpt_run_d[i] = 1'b0;
      end else if (!rpt_run_q[i] && (rpt_cnt_q[i] == RptDelayMax)) begin
        rpt_fire[i]  = 1'b1;
        rpt_cnt_d[i] = '0;
        rpt_run_d[i] = 1'b1;
      end else if (rpt_run_q[i] && (rpt_cnt_q[i] == RptPeriodMax)) begin
        rpt_fire[i]  = 1'b1;
        rpt_cnt_d[i] = '0;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_run_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      rpt_run_q <= rpt_run_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end
`else
  // Without auto-repeat no extra press pulses are ever generated.
  logic [N_BTN-1:0] rpt_fire;
  assign rpt_fire = '0;
`endif

  // -------------------------------------------------------------------------------------------
  // Synchroniser, debounce counter and event pulses
  // -------------------------------------------------------------------------------------------
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        // Any single agreeing sample restarts the stability count.
        cnt_d[i] = '0;
      end else if (accept[i]) begin
        level_d[i]   = sync2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Repeats only fire while the level holds at 1 with no transition accepted, so they can
    // never coincide with a release pulse.
    press_d = press_d | rpt_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed testbench for button_debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Edge numbers count rising edges from the first edge that samples a new raw
// value; outputs are sampled 1 time unit after each rising edge.
module tb_button_debounce_pulse;

  localparam int unsigned NBtn = 3;

  logic            clk;
  logic            rst_n;
  logic [NBtn-1:0] btn_raw;
  logic [NBtn-1:0] btn_level;
  logic [NBtn-1:0] btn_press;
  logic [NBtn-1:0] btn_release;

  int n_checks = 0;
  int n_errors = 0;

  button_debounce_pulse #(
    .N_BTN          (NBtn),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NBtn-1:0] lvl,
                            input logic [NBtn-1:0] prs, input logic [NBtn-1:0] rel);
    check({tag, " level"}, 32'(btn_level), 32'(lvl));
    check({tag, " press"}, 32'(btn_press), 32'(prs));
    check({tag, " release"}, 32'(btn_release), 32'(rel));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NBtn-1:0] acc;
  logic [NBtn-1:0] exp_lvl;
  logic [NBtn-1:0] exp_prs;

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    tick();
    tick();
    check_outs("reset", 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;

    // 1: idle for 50 cycles, nothing may move.
    acc = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      acc = acc | btn_level | btn_press | btn_release;
    end
    check("t1 idle outputs", 32'(acc), 32'd0);

    // 2: raise channel 1 and hold; accepted at edge 6.
    btn_raw = 3'b010;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_outs($sformatf("t2 e%0d", e), (e >= 6) ? 3'b010 : 3'b000,
                 (e == 6) ? 3'b010 : 3'b000, 3'b000);
    end
    btn_raw = 3'b000;
    repeat (10) tick();
    check_outs("t2 released", 3'b000, 3'b000, 3'b000);

    // 3: bounces on channel 0 shorter than the debounce window never propagate.
    for (int e = 1; e <= 16; e++) begin
      btn_raw = ((e <= 3) || (e >= 5 && e <= 7)) ? 3'b001 : 3'b000;
      tick();
      check_outs($sformatf("t3 e%0d", e), 3'b000, 3'b000, 3'b000);
    end

    // 4: establish channel 2 high, then drop it; release accepted at edge 6.
    btn_raw = 3'b100;
    repeat (8) tick();
    check_outs("t4 pressed", 3'b100, 3'b000, 3'b000);
    btn_raw = 3'b000;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_outs($sformatf("t4 e%0d", e), (e < 6) ? 3'b100 : 3'b000, 3'b000,
                 (e == 6) ? 3'b100 : 3'b000);
    end

    // 5: simultaneous press on all channels.
    btn_raw = 3'b111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("t5a e%0d", e), (e >= 6) ? 3'b111 : 3'b000,
                 (e == 6) ? 3'b111 : 3'b000, 3'b000);
    end
    btn_raw = 3'b000;
    repeat (10) tick();
    check_outs("t5 released", 3'b000, 3'b000, 3'b000);

    // 5b: reset in the middle of a second press count, buttons held through reset.
    btn_raw = 3'b111;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_outs("t5 in reset", 3'b000, 3'b000, 3'b000);
    tick();
    tick();
    check_outs("t5 held reset", 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("t5b e%0d", e), (e >= 6) ? 3'b111 : 3'b000,
                 (e == 6) ? 3'b111 : 3'b000, 3'b000);
    end
    btn_raw = 3'b000;
    repeat (10) tick();
    check_outs("t5b released", 3'b000, 3'b000, 3'b000);

    // 6: long hold on channel 1. Press at edge 6; with auto-repeat, further presses at edges
    // 26 and 34. The next repeat would land on edge 42, exactly where the release is accepted.
    btn_raw = 3'b010;
    for (int e = 1; e <= 36; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 3'b010 : 3'b000;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
      exp_prs = (e == 6 || e == 26 || e == 34) ? 3'b010 : 3'b000;
`else
      exp_prs = (e == 6) ? 3'b010 : 3'b000;
`endif
      check_outs($sformatf("t6 e%0d", e), exp_lvl, exp_prs, 3'b000);
    end
    btn_raw = 3'b000;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_outs($sformatf("t6 rel e%0d", e), (e < 6) ? 3'b010 : 3'b000, 3'b000,
                 (e == 6) ? 3'b010 : 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
